// File: rtl/complex_divide2.sv
// Sequential complex divider: quot = (a+bi)/(c+di) using one shared multiplier,
// one add/sub unit and one divider, sequenced by a fixed 11-cycle FSM.
module complex_divide2 #(
  parameter int SIG_WIDTH = 16,
  parameter int EXP_WIDTH = 7
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [2*(SIG_WIDTH+EXP_WIDTH+1)-1:0]     element1,
  input  logic [2*(SIG_WIDTH+EXP_WIDTH+1)-1:0]     element2,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [2*(SIG_WIDTH+EXP_WIDTH+1)-1:0]     quot,
  output logic                                     div_by_zero,
  output logic                                     out_valid,
  input  logic                                     out_ready
);

  localparam int FW = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int MW = SIG_WIDTH + 1;
  localparam int PW = 2 * MW;
  localparam int AW = 2 * MW + 2;
  localparam int QW = MW + 3;
  localparam int XW = EXP_WIDTH + 3;
  localparam logic [EXP_WIDTH-1:0] EMAX   = {EXP_WIDTH{1'b1}};
  localparam logic signed [XW-1:0] E_ZERO = {XW{1'b0}};
  localparam logic signed [XW-1:0] E_ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] E_INF  = {{(XW-EXP_WIDTH){1'b0}}, EMAX};
  localparam logic signed [XW-1:0] BIAS   = {{(XW-EXP_WIDTH+1){1'b0}}, {(EXP_WIDTH-1){1'b1}}};

  typedef logic [FW-1:0] fp_t;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_M1 = 4'd1, S_M2 = 4'd2, S_A1 = 4'd3, S_M3 = 4'd4,
    S_M4 = 4'd5, S_A2 = 4'd6, S_M5 = 4'd7, S_M6 = 4'd8, S_A3 = 4'd9,
    S_D1 = 4'd10, S_D2 = 4'd11, S_DONE = 4'd12
  } state_t;

  function automatic logic signed [XW-1:0] fp_exp(input fp_t x);
    return signed'({{(XW-EXP_WIDTH){1'b0}}, x[FW-2:SIG_WIDTH]});
  endfunction

  function automatic logic fp_is_zero(input fp_t x);
    return (x[FW-2:SIG_WIDTH] == {EXP_WIDTH{1'b0}});
  endfunction

  // Round-to-nearest-even, then flush underflow to +0 and saturate overflow to inf.
  function automatic fp_t fp_pack(input logic s, input logic signed [XW-1:0] e,
                                  input logic [MW-1:0] m, input logic g, input logic st);
    logic [MW:0]           rm;
    logic signed [XW-1:0]  ex;
    fp_t                   r;
    rm = {1'b0, m} + {{MW{1'b0}}, g & (st | m[0])};
    ex = e;
    if (rm[MW]) begin
      rm = rm >> 1;
      ex = ex + E_ONE;
    end else begin
      ex = e;
    end
    if (ex <= E_ZERO) begin
      r = {FW{1'b0}};
    end else if (ex >= E_INF) begin
      r = {s, EMAX, {SIG_WIDTH{1'b0}}};
    end else begin
      r = {s, ex[EXP_WIDTH-1:0], rm[SIG_WIDTH-1:0]};
    end
    return r;
  endfunction

  function automatic fp_t fp_mul(input fp_t x, input fp_t y);
    logic [PW-1:0]         p;
    logic signed [XW-1:0]  e;
    logic                  s;
    fp_t                   r;
    s = x[FW-1] ^ y[FW-1];
    p = {{(PW-MW){1'b0}}, 1'b1, x[SIG_WIDTH-1:0]} * {{(PW-MW){1'b0}}, 1'b1, y[SIG_WIDTH-1:0]};
    e = fp_exp(x) + fp_exp(y) - BIAS;
    if (fp_is_zero(x) || fp_is_zero(y)) begin
      r = {FW{1'b0}};
    end else if (p[PW-1]) begin
      r = fp_pack(s, e + E_ONE, p[PW-1 -: MW], p[PW-1-MW], |p[PW-2-MW:0]);
    end else begin
      r = fp_pack(s, e, p[PW-2 -: MW], p[PW-2-MW], |p[PW-3-MW:0]);
    end
    return r;
  endfunction

  // Computes x + y, or x - y when sub is set; the larger magnitude sets the sign.
  function automatic fp_t fp_add(input fp_t x, input fp_t y, input logic sub);
    fp_t                   yy, big, sml, r;
    logic [EXP_WIDTH-1:0]  d;
    logic [AW-1:0]         ma, mb, mask, sum;
    logic signed [XW-1:0]  e;
    logic                  found;
    int                    lz;
    yy = {y[FW-1] ^ sub, y[FW-2:0]};
    if (x[FW-2:0] >= yy[FW-2:0]) begin
      big = x;
      sml = yy;
    end else begin
      big = yy;
      sml = x;
    end
    d    = big[FW-2:SIG_WIDTH] - sml[FW-2:SIG_WIDTH];
    ma   = {2'b01, big[SIG_WIDTH-1:0], {(MW+1){1'b0}}};
    mb   = {2'b01, sml[SIG_WIDTH-1:0], {(MW+1){1'b0}}};
    mask = ({{(AW-1){1'b0}}, 1'b1} << d) - {{(AW-1){1'b0}}, 1'b1};
    mb   = (mb >> d) | {{(AW-1){1'b0}}, |(mb & mask)};
    if (big[FW-1] == sml[FW-1]) begin
      sum = ma + mb;
    end else begin
      sum = ma - mb;
    end
    e     = fp_exp(big);
    lz    = 0;
    found = 1'b0;
    if (fp_is_zero(x)) begin
      r = fp_is_zero(yy) ? {FW{1'b0}} : yy;
    end else if (fp_is_zero(yy)) begin
      r = x;
    end else if (sum == {AW{1'b0}}) begin
      r = {FW{1'b0}};
    end else begin
      if (sum[AW-1]) begin
        sum = {1'b0, sum[AW-1:1]} | {{(AW-1){1'b0}}, sum[0]};
        e   = e + E_ONE;
      end else begin
        for (int i = AW - 2; i >= 0; i--) begin
          if (!found) begin
            if (sum[i]) found = 1'b1;
            else lz = lz + 1;
          end else begin
            found = 1'b1;
          end
        end
        sum = sum << lz;
        e   = e - signed'(XW'(lz));
      end
      r = fp_pack(big[FW-1], e, sum[AW-2 -: MW], sum[AW-2-MW], |sum[AW-3-MW:0]);
    end
    return r;
  endfunction

  function automatic fp_t fp_div(input fp_t x, input fp_t y);
    logic [AW-1:0]         n, dv, qq, rem;
    logic signed [XW-1:0]  e;
    logic                  s;
    fp_t                   r;
    s   = x[FW-1] ^ y[FW-1];
    n   = {1'b1, x[SIG_WIDTH-1:0], {(MW+2){1'b0}}};
    dv  = {{(AW-MW){1'b0}}, 1'b1, y[SIG_WIDTH-1:0]};
    qq  = n / dv;
    rem = n % dv;
    e   = fp_exp(x) - fp_exp(y) + BIAS;
    if (fp_is_zero(y)) begin
      r = {s, EMAX, {SIG_WIDTH{1'b0}}};
    end else if (fp_is_zero(x)) begin
      r = {FW{1'b0}};
    end else if (qq[QW-1]) begin
      r = fp_pack(s, e, qq[QW-1 -: MW], qq[QW-1-MW], (|qq[QW-2-MW:0]) | (|rem));
    end else begin
      r = fp_pack(s, e - E_ONE, qq[QW-2 -: MW], qq[QW-2-MW], (|qq[QW-3-MW:0]) | (|rem));
    end
    return r;
  endfunction

  state_t     state_q, state_d;
  fp_t        a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  fp_t        t0_q, t1_q, den_q, nr_q, ni_q, t0_d, t1_d, den_d, nr_d, ni_d;
  logic [2*FW-1:0] quot_q, quot_d;
  logic       zero_q, zero_d, dbz_q, dbz_d, out_valid_q, out_valid_d;
  fp_t        mul_a_s, mul_b_s, mul_y_s, add_y_s, div_y_s;

  // Operand routing into the shared multiplier for each multiply state.
  always_comb begin
    mul_a_s = c_q;
    mul_b_s = c_q;
    case (state_q)
      S_M2:    begin mul_a_s = d_q; mul_b_s = d_q; end
      S_M3:    begin mul_a_s = a_q; mul_b_s = c_q; end
      S_M4:    begin mul_a_s = b_q; mul_b_s = d_q; end
      S_M5:    begin mul_a_s = b_q; mul_b_s = c_q; end
      S_M6:    begin mul_a_s = a_q; mul_b_s = d_q; end
      default: begin mul_a_s = c_q; mul_b_s = c_q; end
    endcase
  end

  assign mul_y_s = fp_mul(mul_a_s, mul_b_s);
  assign add_y_s = fp_add(t0_q, t1_q, state_q == S_A3);
  assign div_y_s = fp_div((state_q == S_D2) ? ni_q : nr_q, den_q);

  // Sequencer: each state commits exactly one unit result.
  always_comb begin
    state_d     = state_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    t0_d = t0_q; t1_d = t1_q; den_d = den_q; nr_d = nr_q; ni_d = ni_q;
    quot_d      = quot_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = element1[2*FW-1:FW];
          b_d     = element1[FW-1:0];
          c_d     = element2[2*FW-1:FW];
          d_d     = element2[FW-1:0];
          state_d = S_M1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_M1: begin t0_d = mul_y_s; state_d = S_M2; end
      S_M2: begin t1_d = mul_y_s; state_d = S_A1; end
      S_A1: begin
        den_d   = add_y_s;
        zero_d  = fp_is_zero(add_y_s);
        state_d = S_M3;
      end
      S_M3: begin t0_d = mul_y_s; state_d = S_M4; end
      S_M4: begin t1_d = mul_y_s; state_d = S_A2; end
      S_A2: begin nr_d = add_y_s; state_d = S_M5; end
      S_M5: begin t0_d = mul_y_s; state_d = S_M6; end
      S_M6: begin t1_d = mul_y_s; state_d = S_A3; end
      S_A3: begin ni_d = add_y_s; state_d = S_D1; end
      S_D1: begin
        quot_d[2*FW-1:FW] = zero_q ? {FW{1'b0}} : div_y_s;
        state_d           = S_D2;
      end
      S_D2: begin
        quot_d[FW-1:0] = zero_q ? {FW{1'b0}} : div_y_s;
        dbz_d          = zero_q;
        out_valid_d    = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= {FW{1'b0}}; b_q <= {FW{1'b0}}; c_q <= {FW{1'b0}}; d_q <= {FW{1'b0}};
      t0_q <= {FW{1'b0}}; t1_q <= {FW{1'b0}}; den_q <= {FW{1'b0}};
      nr_q <= {FW{1'b0}}; ni_q <= {FW{1'b0}};
      quot_q      <= {(2*FW){1'b0}};
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      t0_q <= t0_d; t1_q <= t1_d; den_q <= den_d;
      nr_q <= nr_d; ni_q <= ni_d;
      quot_q      <= quot_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign quot        = quot_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_complex_divide2.sv
// Directed self-checking bench for complex_divide2: hand-computed quotients,
// latency, zero divisor, backpressure and reset during an operation.
module tb_complex_divide2;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] element1, element2, quot;
  logic        in_valid, in_ready, div_by_zero, out_valid, out_ready;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clock = ~clock;

  complex_divide2 dut (
    .clock(clock), .reset(reset), .element1(element1), .element2(element2),
    .in_valid(in_valid), .in_ready(in_ready), .quot(quot),
    .div_by_zero(div_by_zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Issue one operation with out_ready=1 and report what the DUT returned.
  task automatic run_op(input logic [47:0] e1, input logic [47:0] e2, output logic acc,
                        output int lat, output logic [47:0] q, output logic dbz,
                        output logic single);
    @(negedge clock);
    element1 = e1; element2 = e2; in_valid = 1'b1; out_ready = 1'b1;
    acc = in_ready;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    q = 48'h0; dbz = 1'b0;
    while (lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (out_valid) break;
    end
    q = quot; dbz = div_by_zero;
    @(posedge clock); #1;
    single = !out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    element1 = 48'h0; element2 = 48'h0;
    repeat (2) @(negedge clock);
    tests_run++; if (quot !== 48'h0) begin tests_failed++; $display("FAIL reset_quot: got %h expected %h", quot, 48'h0); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_divide();
    logic [47:0] e1 [5] = '{48'h3F0000_000000, 48'h000000_400000, 48'h3F0000_000000, 48'h410000_400000, 48'h3F0000_000000};
    logic [47:0] e2 [5] = '{48'h3F0000_000000, 48'h400000_000000, 48'h000000_3F0000, 48'h3F0000_3F0000, 48'h408000_000000};
    logic [47:0] ex [5] = '{48'h3F0000_000000, 48'h000000_3F0000, 48'h000000_BF0000, 48'h408000_BF0000, 48'h3D5555_000000};
    logic acc, dbz, single; int lat; logic [47:0] q;
    for (int i = 0; i < 5; i++) begin
      run_op(e1[i], e2[i], acc, lat, q, dbz, single);
      tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL div%0d_accept: got in_ready=%b expected 1", i, acc); end
      tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL div%0d_latency: got %0d expected 11", i, lat); end
      tests_run++; if (q !== ex[i]) begin tests_failed++; $display("FAIL div%0d_quot: got %h expected %h", i, q, ex[i]); end
      tests_run++; if (dbz !== 1'b0) begin tests_failed++; $display("FAIL div%0d_dbz: got %b expected 0", i, dbz); end
      tests_run++; if (single !== 1'b1) begin tests_failed++; $display("FAIL div%0d_pulse: out_valid still high after handshake", i); end
    end
  endtask

  task automatic test_zero_divisor();
    logic acc, dbz, single; int lat; logic [47:0] q;
    run_op(48'h400000_400000, 48'h000000_000000, acc, lat, q, dbz, single);
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL zero_latency: got %0d expected 11", lat); end
    tests_run++; if (q !== 48'h0) begin tests_failed++; $display("FAIL zero_quot: got %h expected %h", q, 48'h0); end
    tests_run++; if (dbz !== 1'b1) begin tests_failed++; $display("FAIL zero_dbz: got %b expected 1", dbz); end
    run_op(48'h3F0000_000000, 48'h3F0000_000000, acc, lat, q, dbz, single);
    tests_run++; if (dbz !== 1'b0) begin tests_failed++; $display("FAIL zero_next_dbz: got %b expected 0", dbz); end
    tests_run++; if (q !== 48'h3F0000_000000) begin tests_failed++; $display("FAIL zero_next_quot: got %h expected %h", q, 48'h3F0000_000000); end
  endtask

  task automatic test_back_to_back();
    int lat; logic seen;
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1;
    element1 = 48'h410000_400000; element2 = 48'h3F0000_3F0000;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_idle: got in_ready=%b expected 1", in_ready); end
    @(posedge clock);
    @(negedge clock);
    element1 = 48'h000000_400000; element2 = 48'h400000_000000;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin @(posedge clock); #1; lat++; seen = out_valid; end
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL bp_latency: got %0d expected 11", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, out_valid); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_hold_ready%0d: got %b expected 0", i, in_ready); end
      tests_run++; if (quot !== 48'h408000_BF0000) begin tests_failed++; $display("FAIL bp_hold_quot%0d: got %h expected %h", i, quot, 48'h408000_BF0000); end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_after_valid: got %b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_after_ready: got %b expected 1", in_ready); end
    tests_run++; if (quot !== 48'h408000_BF0000) begin tests_failed++; $display("FAIL bp_after_quot: got %h expected %h", quot, 48'h408000_BF0000); end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin @(posedge clock); #1; lat++; seen = out_valid; end
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL bp_second_latency: got %0d expected 11", lat); end
    tests_run++; if (quot !== 48'h000000_3F0000) begin tests_failed++; $display("FAIL bp_second_quot: got %h expected %h", quot, 48'h000000_3F0000); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_op();
    logic acc, dbz, single, spurious; int lat; logic [47:0] q;
    @(negedge clock);
    element1 = 48'h410000_400000; element2 = 48'h3F0000_3F0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    tests_run++; if (quot !== 48'h0) begin tests_failed++; $display("FAIL rst_mid_quot: got %h expected %h", quot, 48'h0); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
    @(negedge clock);
    reset = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 15; i++) begin @(negedge clock); if (out_valid) spurious = 1'b1; end
    tests_run++; if (spurious !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_result: got out_valid pulse expected none"); end
    run_op(48'h3F0000_000000, 48'h3F0000_000000, acc, lat, q, dbz, single);
    tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL rst_next_accept: got %b expected 1", acc); end
    tests_run++; if (lat !== 11) begin tests_failed++; $display("FAIL rst_next_latency: got %0d expected 11", lat); end
    tests_run++; if (q !== 48'h3F0000_000000) begin tests_failed++; $display("FAIL rst_next_quot: got %h expected %h", q, 48'h3F0000_000000); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_zero_divisor();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
